// File: rtl/bg_fetch_sequencer_if.sv
// bg_fetch_sequencer_if: line-control, arbiter-handshake and fetch-strobe bundle for the background fetch sequencer
interface bg_fetch_sequencer_if #(
    parameter int SLOT_CYCLES    = 12,
    parameter int TILES_PER_LINE = 40,
    parameter int NUM_LAYERS     = 2,
    parameter int PAN_BITS       = 4
);
    localparam int PW = $clog2(SLOT_CYCLES);
    localparam int TW = $clog2(TILES_PER_LINE + 2);
    logic                           line_start;
    logic [NUM_LAYERS-1:0]          layer_en;
    logic [NUM_LAYERS*PAN_BITS-1:0] pan;
    logic                           mem_ready;
    logic [NUM_LAYERS-1:0]          char_addr_stb, char_data_stb;
    logic [NUM_LAYERS-1:0]          pal_addr_stb, pal_data_stb;
    logic [NUM_LAYERS-1:0]          tile_lo_addr_stb, tile_lo_data_stb;
    logic [NUM_LAYERS-1:0]          tile_hi_addr_stb, tile_hi_data_stb;
    logic                           pixel_valid;
    logic [PW-1:0]                  phase;
    logic [TW-1:0]                  tile_idx;
    logic                           line_busy;
    logic                           line_done;
    modport master (
        input  line_start, layer_en, pan, mem_ready,
        output char_addr_stb, char_data_stb, pal_addr_stb, pal_data_stb,
               tile_lo_addr_stb, tile_lo_data_stb, tile_hi_addr_stb, tile_hi_data_stb,
               pixel_valid, phase, tile_idx, line_busy, line_done
    );
    modport slave (
        output line_start, layer_en, pan, mem_ready,
        input  char_addr_stb, char_data_stb, pal_addr_stb, pal_data_stb,
               tile_lo_addr_stb, tile_lo_data_stb, tile_hi_addr_stb, tile_hi_data_stb,
               pixel_valid, phase, tile_idx, line_busy, line_done
    );
endinterface

// File: rtl/bg_fetch_sequencer.sv
// bg_fetch_sequencer: per-layer fetch strobes and pixel window for one scanline, one tile period at a time
module bg_fetch_sequencer #(
    parameter int SLOT_CYCLES    = 12,
    parameter int TILES_PER_LINE = 40,
    parameter int NUM_LAYERS     = 2,
    parameter int PAN_BITS       = 4
) (
    input logic clk,
    input logic rst,
    bg_fetch_sequencer_if.master bus
);
    localparam int PW = $clog2(SLOT_CYCLES);
    localparam int TW = $clog2(TILES_PER_LINE + 2);
    logic [PW-1:0]                      phaseQ;
    logic [TW-1:0]                      tileQ, nMax;
    logic                               busyQ, doneQ, adv, lastPhase, endLine;
    logic [NUM_LAYERS-1:0]              enQ, panNz;
    logic [NUM_LAYERS*PAN_BITS-1:0]     panQ;
    logic [4:0][NUM_LAYERS-1:0]         hit;
    // a panned layer needs one extra partially visible tile; the line lasts as long as the longest enabled layer
    assign nMax      = TW'(TILES_PER_LINE) + TW'(|(enQ & panNz));
    assign adv       = busyQ && bus.mem_ready;
    assign lastPhase = phaseQ == PW'(SLOT_CYCLES - 1);
    assign endLine   = adv && lastPhase && (tileQ + 1'b1 == nMax);
    for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
        logic act;
        assign panNz[l] = panQ[l*PAN_BITS +: PAN_BITS] != '0;
        assign act      = adv && enQ[l] && (tileQ < TW'(TILES_PER_LINE) + TW'(panNz[l]));
        for (genvar k = 0; k < 5; k++) begin : g_slot
            assign hit[k][l] = act && (phaseQ == PW'(5*l + k));
        end
    end
    assign bus.char_addr_stb    = hit[0];
    assign bus.char_data_stb    = hit[1];
    assign bus.pal_addr_stb     = hit[2];
    assign bus.tile_lo_addr_stb = hit[2];
    assign bus.pal_data_stb     = hit[3];
    assign bus.tile_lo_data_stb = hit[3];
    assign bus.tile_hi_addr_stb = hit[3];
    assign bus.tile_hi_data_stb = hit[4];
    assign bus.pixel_valid      = adv && (phaseQ >= PW'(SLOT_CYCLES - 8));
    assign bus.phase            = phaseQ;
    assign bus.tile_idx         = tileQ;
    assign bus.line_busy        = busyQ;
    assign bus.line_done        = doneQ;
    always_ff @(posedge clk) begin
        if (rst) begin
            phaseQ <= '0;
            tileQ  <= '0;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            enQ    <= '0;
            panQ   <= '0;
        end else begin
            doneQ <= endLine;
            if (bus.line_start) begin
                busyQ  <= 1'b1;
                phaseQ <= '0;
                tileQ  <= '0;
                enQ    <= bus.layer_en;
                panQ   <= bus.pan;
            end else if (adv) begin
                phaseQ <= lastPhase ? '0 : phaseQ + 1'b1;
                tileQ  <= !lastPhase ? tileQ : endLine ? '0 : tileQ + 1'b1;
                if (endLine) busyQ <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bg_fetch_sequencer.sv
// tb_bg_fetch_sequencer: directed scenarios plus random traffic checked against a cycle-count reference model
module tb_bg_fetch_sequencer;
    localparam int S  = 12;
    localparam int T  = 40;
    localparam int NL = 2;
    localparam int PB = 4;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    bg_fetch_sequencer_if #(.SLOT_CYCLES(S), .TILES_PER_LINE(T), .NUM_LAYERS(NL), .PAN_BITS(PB)) bus ();
    bg_fetch_sequencer #(.SLOT_CYCLES(S), .TILES_PER_LINE(T), .NUM_LAYERS(NL), .PAN_BITS(PB)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    int total = 0;
    int bad = 0;
    bit mBusy = 0, mDone = 0, prevBusy = 0;
    int mCount = 0, lenCnt = 0, expLen = 0;
    logic [NL-1:0] mEn = '0;
    logic [NL*PB-1:0] mPan = '0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // model view: position in the line is just the number of advancing cycles so far
    task automatic step(input logic ls, input logic rdy, input logic r, input logic [NL-1:0] en, input logic [NL*PB-1:0] pn);
        logic [NL-1:0] e [5];
        int nMax, ph, tl;
        bit adv, anyPan, comp;
        @(negedge clk);
        bus.line_start = ls; bus.mem_ready = rdy; rst = r; bus.layer_en = en; bus.pan = pn;
        #1;
        anyPan = 0;
        for (int l = 0; l < NL; l++) if (mEn[l] && mPan[l*PB +: PB] != 0) anyPan = 1;
        nMax = T + int'(anyPan);
        ph = mCount % S;
        tl = mCount / S;
        adv = mBusy && rdy;
        for (int k = 0; k < 5; k++)
            for (int l = 0; l < NL; l++)
                e[k][l] = adv && mEn[l] && (tl < T + ((mPan[l*PB +: PB] != 0) ? 1 : 0)) && (ph == 5*l + k);
        checkEq("char_addr", 32'(bus.char_addr_stb), 32'(e[0]));
        checkEq("char_data", 32'(bus.char_data_stb), 32'(e[1]));
        checkEq("pal_addr", 32'(bus.pal_addr_stb), 32'(e[2]));
        checkEq("tile_lo_addr", 32'(bus.tile_lo_addr_stb), 32'(e[2]));
        checkEq("pal_data", 32'(bus.pal_data_stb), 32'(e[3]));
        checkEq("tile_lo_data", 32'(bus.tile_lo_data_stb), 32'(e[3]));
        checkEq("tile_hi_addr", 32'(bus.tile_hi_addr_stb), 32'(e[3]));
        checkEq("tile_hi_data", 32'(bus.tile_hi_data_stb), 32'(e[4]));
        checkEq("pixel_valid", 32'(bus.pixel_valid), 32'(adv && ph >= S - 8));
        checkEq("phase", 32'(bus.phase), 32'(ph));
        checkEq("tile_idx", 32'(bus.tile_idx), 32'(tl));
        checkEq("line_busy", 32'(bus.line_busy), 32'(mBusy));
        checkEq("line_done", 32'(bus.line_done), 32'(mDone));
        if (bus.line_busy === 1'b1 && !prevBusy) lenCnt = 0; else lenCnt++;
        prevBusy = (bus.line_busy === 1'b1);
        if (bus.line_done === 1'b1 && expLen > 0) checkEq("line_len", 32'(lenCnt), 32'(expLen));
        comp = adv && (mCount + 1 == nMax * S);
        if (r) begin
            mBusy = 0; mDone = 0; mCount = 0; mEn = '0; mPan = '0;
        end else begin
            mDone = comp;
            if (ls) begin
                mBusy = 1; mCount = 0; mEn = en; mPan = pn;
            end else if (adv) begin
                if (comp) begin mBusy = 0; mCount = 0; end
                else mCount++;
            end
        end
    endtask

    task automatic runLine(input int n, input logic [NL-1:0] en, input logic [NL*PB-1:0] pn);
        step(1, 1, 0, en, pn);
        for (int i = 0; i < n; i++) step(0, 1, 0, '0, '0);
    endtask

    initial begin
        rst = 1; bus.line_start = 0; bus.mem_ready = 1; bus.layer_en = '0; bus.pan = '0;
        repeat (2) @(posedge clk);
        step(0, 1, 1, '0, '0);
        step(0, 1, 0, '0, '0);
        expLen = 480; runLine(490, 2'b11, 8'h00);
        expLen = 492; runLine(500, 2'b11, 8'h03);
        expLen = 483;
        step(1, 1, 0, 2'b11, 8'h00);
        for (int i = 0; i < 5*S + 2; i++) step(0, 1, 0, '0, '0);
        repeat (3) step(0, 0, 0, '0, '0);
        for (int i = 0; i < 430; i++) step(0, 1, 0, '0, '0);
        expLen = 0;
        step(1, 1, 0, 2'b11, 8'h00);
        for (int i = 0; i < 10*S; i++) step(0, 1, 0, '0, '0);
        runLine(500, 2'b11, 8'h21);
        step(1, 1, 0, 2'b11, 8'h04);
        for (int i = 0; i < 20*S; i++) step(0, 1, 0, '0, '0);
        step(0, 1, 1, '0, '0);
        for (int i = 0; i < 60; i++) step(0, 1, 0, '0, '0);
        expLen = 480; runLine(490, 2'b00, 8'h05);
        expLen = 0;
        for (int i = 0; i < 9000; i++) begin
            logic ls;
            ls = mBusy ? ($urandom_range(0, 799) == 0) : ($urandom_range(0, 15) == 0);
            step(ls, ($urandom_range(0, 7) != 0), ($urandom_range(0, 2999) == 0),
                 NL'($urandom), (NL*PB)'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bg_fetch_sequencer.md
Name: bg_fetch_sequencer

Overview:
- Generates per-layer memory-fetch strobes (char, palette, tile-low, tile-high) and the pixel-output window for the background renderer, one tile period at a time, across one scanline.
- Sits between the line timing generator (line_start) and the shared video memory arbiter.
- Adds the following:
  - parametrised tile-period length, tiles per line and layer count;
  - per-layer enable and per-layer fine pan;
  - a memory stall handshake;
  - line-done reporting.

Parameters:
- SLOT_CYCLES, 12, cycles per tile period. Must be ≥ 5*NUM_LAYERS and ≥ 8.
- TILES_PER_LINE, 40, visible tiles per line at zero pan.
- NUM_LAYERS, 2, number of background layers time-multiplexed in each tile period.
- PAN_BITS, 4, width of each layer's fine-pan field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- line_start  in  1  one-cycle pulse that begins a line.
- layer_en  in  NUM_LAYERS  per-layer enable. Sampled at line_start.
- pan  in  NUM_LAYERS*PAN_BITS  per-layer fine pan; layer l uses bits [l*PAN_BITS +: PAN_BITS]. Sampled at line_start.
- mem_ready  in  1  arbiter ready; low stalls the sequencer.
- char_addr_stb, char_data_stb  out  NUM_LAYERS each  character-map address-out / data-in strobes.
- pal_addr_stb, pal_data_stb  out  NUM_LAYERS each  palette address-out / data-in strobes.
- tile_lo_addr_stb, tile_lo_data_stb  out  NUM_LAYERS each  tile low-plane strobes.
- tile_hi_addr_stb, tile_hi_data_stb  out  NUM_LAYERS each  tile high-plane strobes.
- pixel_valid  out  1  pixel shift/output window.
- phase  out  clog2(SLOT_CYCLES)  current phase within the tile period.
- tile_idx  out  clog2(TILES_PER_LINE+2)  index of the tile being fetched.
- line_busy  out  1  sequencer active.
- line_done  out  1  one-cycle pulse at end of line.

Behaviour:
- Reset:
  - phase = 0, tile_idx = 0, line_busy = 0.
  - Sampled enables and pans cleared.
  - All strobes, pixel_valid and line_done = 0.
  - Reset in mid-line aborts the line with no line_done.
- line_start (reset not asserted):
  - On the next cycle: line_busy = 1, phase = 0, tile_idx = 0.
  - layer_en and pan are registered.
  - A line_start while busy restarts the line immediately; no line_done is issued for the aborted line.
- N_max:
  - N_max = TILES_PER_LINE + 1 if any enabled layer has nonzero sampled pan; otherwise N_max = TILES_PER_LINE.
  - Per-layer limit N_l = TILES_PER_LINE + (pan_l != 0).
- Advance: a cycle advances when line_busy && mem_ready.
  - On an advancing cycle, phase increments.
  - At phase == SLOT_CYCLES-1, phase wraps to 0 and tile_idx increments.
  - When tile_idx would reach N_max on that wrap:
    - line_busy clears;
    - line_done pulses for one cycle;
    - tile_idx returns to 0.
  - Total advancing cycles per line = N_max*SLOT_CYCLES.
- Stall: while mem_ready = 0, phase and tile_idx hold, and every strobe and pixel_valid is 0.
- Strobes are combinational from registered state and mem_ready.
  - A layer strobe is active only when line_busy && mem_ready && layer_en_l && tile_idx < N_l.
  - Layer l base phase b = 5*l. Active phases:
    - char_addr at b;
    - char_data at b+1;
    - pal_addr and tile_lo_addr at b+2;
    - pal_data, tile_lo_data and tile_hi_addr at b+3;
    - tile_hi_data at b+4.
- pixel_valid = line_busy && mem_ready && phase ≥ SLOT_CYCLES-8. This gives 8 pixels per tile period, independent of layer enables.
- line_done and line_start coincident: the restart wins, and line_done still pulses for the completed line.
- Disabled layers produce no strobes; the sequencer still runs.
- If all layers are disabled, the sequencer runs for TILES_PER_LINE tiles.

Test Plan:
- Defaults, pan = 0, both layers enabled, mem_ready = 1, pulse line_start:
  - char_addr_stb[0] high on the cycle after line_start;
  - char_addr_stb[1] high 5 cycles later;
  - pixel_valid high at phases 4–11;
  - line_done exactly 480 cycles after line_busy rises.
- Layer 0 pan = 3, layer 1 pan = 0:
  - line lasts 41 tiles (492 cycles);
  - layer 0 strobes during tile 40;
  - layer 1 strobes absent in tile 40.
- mem_ready low for 3 cycles at phase 2 of tile 5:
  - all strobes and pixel_valid are 0;
  - phase holds at 2;
  - line_done is delayed by exactly 3 cycles (483).
- line_start reasserted at tile 10:
  - no line_done;
  - tile_idx = 0 and phase = 0 the next cycle;
  - new pan values take effect.
- rst asserted mid-line at tile 20:
  - all outputs are 0 the next cycle;
  - no line_done;
  - the sequencer stays idle until line_start.
- layer_en = 2'b00, pan[0] = 5:
  - no fetch strobes;
  - 40-tile line (pan of the disabled layer ignored);
  - pixel_valid windows still present.
